// File: rtl/dsp_voice_mixer.sv
// Time-multiplexed stereo voice mixer: one voice per clock into wide accumulators,
// then master volume, saturation to DAC width, and a once-per-frame output latch.
module dsp_voice_mixer #(
  parameter int N_VOICES          = 8,
  parameter int SAMPLE_W          = 16,
  parameter int VOL_W             = 8,
  parameter int CLOCKS_PER_SAMPLE = 64,
  parameter int ACC_W             = 24
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_VOICES*SAMPLE_W-1:0] voice_samples,
  input  logic [N_VOICES*VOL_W-1:0]    voice_vol_l,
  input  logic [N_VOICES*VOL_W-1:0]    voice_vol_r,
  input  logic [N_VOICES-1:0]          voice_enable,
  input  logic [VOL_W-1:0]             master_vol_l,
  input  logic [VOL_W-1:0]             master_vol_r,
  input  logic                         mute,
  output logic [5:0]                   step,
  output logic [SAMPLE_W-1:0]          dac_out_l,
  output logic [SAMPLE_W-1:0]          dac_out_r,
  output logic                         dac_valid,
  output logic                         clip_l,
  output logic                         clip_r
);

  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  // Product widths are generous so the signed multiply never loses bits.
  localparam int PX_W = SAMPLE_W + VOL_W + ACC_W;
  localparam int PM_W = ACC_W + VOL_W;
  localparam logic [5:0] LAST_STEP       = 6'(CLOCKS_PER_SAMPLE - 1);
  localparam logic [5:0] MASTER_STEP     = 6'(N_VOICES + 1);
  localparam logic [5:0] LAST_VOICE_STEP = 6'(N_VOICES);
  localparam logic signed [PM_W-1:0] SAT_MAX =
    {{(PM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [PM_W-1:0] SAT_MIN =
    {{(PM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic [5:0]          step_reg;
  logic [5:0]          step_next;
  logic                dac_valid_reg;
  logic                voice_step;
  logic [IDX_W-1:0]    voice_idx;
  logic [SAMPLE_W-1:0] sample_arr [N_VOICES];
  logic [VOL_W-1:0]    vol_arr    [2][N_VOICES];
  logic [VOL_W-1:0]    master_arr [2];

  always_comb begin
    step_next  = (step_reg == LAST_STEP) ? 6'd0 : step_reg + 6'd1;
    voice_step = (step_reg != 6'd0) && (step_reg <= LAST_VOICE_STEP);
    voice_idx  = IDX_W'(step_reg - 6'd1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_reg      <= 6'd0;
      dac_valid_reg <= 1'b0;
    end else begin
      step_reg      <= step_next;
      dac_valid_reg <= (step_reg == LAST_STEP);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_VOICES; gi++) begin : g_voice
      assign sample_arr[gi]  = voice_samples[gi*SAMPLE_W +: SAMPLE_W];
      assign vol_arr[0][gi]  = voice_vol_l[gi*VOL_W +: VOL_W];
      assign vol_arr[1][gi]  = voice_vol_r[gi*VOL_W +: VOL_W];
    end
  endgenerate

  assign master_arr[0] = master_vol_l;
  assign master_arr[1] = master_vol_r;

  // Channel 0 is left, channel 1 is right; both share the step sequencer.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [ACC_W-1:0] acc_reg;
      logic [SAMPLE_W-1:0]     mast_reg;
      logic                    clip_int_reg;
      logic [SAMPLE_W-1:0]     dac_reg;
      logic                    clip_reg;
      logic [SAMPLE_W-1:0]     cur_sample;
      logic [VOL_W-1:0]        cur_vol;
      logic signed [PX_W-1:0]  vprod;
      logic signed [ACC_W-1:0] term;
      logic signed [PM_W-1:0]  mprod;
      logic signed [PM_W-1:0]  mshift;
      logic [SAMPLE_W-1:0]     sat_val;
      logic                    sat_clip;

      always_comb begin
        cur_sample = sample_arr[voice_idx];
        cur_vol    = vol_arr[gi][voice_idx];
        vprod = $signed({{(PX_W-SAMPLE_W){cur_sample[SAMPLE_W-1]}}, cur_sample}) *
                $signed({{(PX_W-VOL_W){cur_vol[VOL_W-1]}}, cur_vol});
        // Arithmetic shift floors; the scaled term always fits the accumulator.
        term  = ACC_W'(vprod >>> (VOL_W - 1));
        mprod = $signed({{VOL_W{acc_reg[ACC_W-1]}}, acc_reg}) *
                $signed({{ACC_W{master_arr[gi][VOL_W-1]}}, master_arr[gi]});
        mshift = mprod >>> (VOL_W - 1);
        if (mshift > SAT_MAX) begin
          sat_val  = SAMPLE_W'(SAT_MAX);
          sat_clip = 1'b1;
        end else if (mshift < SAT_MIN) begin
          sat_val  = SAMPLE_W'(SAT_MIN);
          sat_clip = 1'b1;
        end else begin
          sat_val  = mshift[SAMPLE_W-1:0];
          sat_clip = 1'b0;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          acc_reg      <= '0;
          mast_reg     <= '0;
          clip_int_reg <= 1'b0;
          dac_reg      <= '0;
          clip_reg     <= 1'b0;
        end else begin
          if (step_reg == 6'd0)
            acc_reg <= '0;
          else if (voice_step && voice_enable[voice_idx])
            acc_reg <= acc_reg + term;
          if (step_reg == MASTER_STEP) begin
            mast_reg     <= sat_val;
            clip_int_reg <= sat_clip;
          end
          // Mute only blanks the audio; the clip flags still report the mix.
          if (step_reg == LAST_STEP) begin
            dac_reg  <= mute ? '0 : mast_reg;
            clip_reg <= clip_int_reg;
          end
        end
      end
    end
  endgenerate

  assign step      = step_reg;
  assign dac_valid = dac_valid_reg;
  assign dac_out_l = g_chan[0].dac_reg;
  assign dac_out_r = g_chan[1].dac_reg;
  assign clip_l    = g_chan[0].clip_reg;
  assign clip_r    = g_chan[1].clip_reg;

endmodule

// File: tb/tb_dsp_voice_mixer.sv
// Directed bench for dsp_voice_mixer: default build plus a minimum-frame
// N_VOICES=4 / CLOCKS_PER_SAMPLE=7 / VOL_W=12 build sharing clock and reset.
module tb_dsp_voice_mixer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset;
  logic [127:0]       voice_samples;
  logic [63:0]        voice_vol_l, voice_vol_r;
  logic [7:0]         voice_enable, master_vol_l, master_vol_r;
  logic               mute;
  logic [5:0]         step;
  logic signed [15:0] dac_out_l, dac_out_r;
  logic               dac_valid, clip_l, clip_r;

  logic [63:0]        s2;
  logic [47:0]        vl2, vr2;
  logic [3:0]         en2;
  logic [11:0]        ml2, mr2;
  logic               mute2;
  logic [5:0]         step2;
  logic signed [15:0] dl2, dr2;
  logic               valid2, cl2, cr2;

  int n_vec = 0;
  int n_err = 0;

  dsp_voice_mixer dut (
    .clock(clock), .reset(reset), .voice_samples(voice_samples),
    .voice_vol_l(voice_vol_l), .voice_vol_r(voice_vol_r), .voice_enable(voice_enable),
    .master_vol_l(master_vol_l), .master_vol_r(master_vol_r), .mute(mute),
    .step(step), .dac_out_l(dac_out_l), .dac_out_r(dac_out_r),
    .dac_valid(dac_valid), .clip_l(clip_l), .clip_r(clip_r)
  );

  dsp_voice_mixer #(
    .N_VOICES(4), .SAMPLE_W(16), .VOL_W(12), .CLOCKS_PER_SAMPLE(7), .ACC_W(24)
  ) dut2 (
    .clock(clock), .reset(reset), .voice_samples(s2),
    .voice_vol_l(vl2), .voice_vol_r(vr2), .voice_enable(en2),
    .master_vol_l(ml2), .master_vol_r(mr2), .mute(mute2),
    .step(step2), .dac_out_l(dl2), .dac_out_r(dr2),
    .dac_valid(valid2), .clip_l(cl2), .clip_r(cr2)
  );

  task automatic set_voice(input int v, input logic [15:0] s, input logic [7:0] vl,
                           input logic [7:0] vr);
    voice_samples[v*16 +: 16] = s;
    voice_vol_l[v*8 +: 8]     = vl;
    voice_vol_r[v*8 +: 8]     = vr;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (dac_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_valid2(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (valid2) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int c;
    reset = 1'b1;
    voice_samples = '0; voice_vol_l = '0; voice_vol_r = '0; voice_enable = '0;
    master_vol_l = '0; master_vol_r = '0; mute = 1'b0;
    s2 = '0; vl2 = '0; vr2 = '0; en2 = '0; ml2 = '0; mr2 = '0; mute2 = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++;
    if (step !== 6'd0 || step2 !== 6'd0) begin
      n_err++; $display("FAIL reset_step: got %0d/%0d want 0/0", step, step2);
    end
    n_vec++;
    if (dac_out_l !== 16'sd0 || dac_out_r !== 16'sd0 || dac_valid !== 1'b0 ||
        clip_l !== 1'b0 || clip_r !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got l=%0d r=%0d v=%b cl=%b cr=%b want all 0",
                        dac_out_l, dac_out_r, dac_valid, clip_l, clip_r);
    end
    reset = 1'b0;
    wait_valid(c);
    n_vec++;
    if (c != 64) begin
      n_err++; $display("FAIL first_valid_latency: got %0d want 64", c);
    end
    $display("reset: first dac_valid after %0d cycles", c);
  endtask

  task automatic test_single_voice();
    int c;
    wait_valid(c);
    voice_samples = '0; voice_vol_l = '0; voice_vol_r = '0;
    set_voice(0, 16'h4000, 8'h7F, 8'h00);
    voice_enable = 8'h01; master_vol_l = 8'h7F; master_vol_r = 8'h7F;
    wait_valid(c);
    n_vec++;
    if (c != 64) begin
      n_err++; $display("FAIL single_period: got %0d want 64", c);
    end
    n_vec++;
    if (dac_out_l !== 16129 || dac_out_r !== 0 || clip_l !== 1'b0) begin
      n_err++; $display("FAIL single_value: got l=%0d r=%0d clip=%b want 16129 0 0",
                        dac_out_l, dac_out_r, clip_l);
    end
    @(negedge clock);
    n_vec++;
    if (dac_valid !== 1'b0) begin
      n_err++; $display("FAIL single_pulse_width: got valid=%b want 0", dac_valid);
    end
    wait_valid(c);
    n_vec++;
    if (c != 63 || dac_out_l !== 16129) begin
      n_err++; $display("FAIL single_hold: got gap=%0d l=%0d want 63 16129", c, dac_out_l);
    end
    $display("single_voice: l=%0d r=%0d clip_l=%b", dac_out_l, dac_out_r, clip_l);
  endtask

  task automatic test_saturation();
    int c;
    for (int v = 0; v < 8; v++) set_voice(v, 16'h7FFF, 8'h7F, 8'h7F);
    voice_enable = 8'hFF;
    wait_valid(c);
    n_vec++;
    if (c < 0 || dac_out_l !== 32767 || dac_out_r !== 32767 || clip_l !== 1'b1 || clip_r !== 1'b1) begin
      n_err++; $display("FAIL sat_pos: got l=%0d r=%0d cl=%b cr=%b want 32767 32767 1 1",
                        dac_out_l, dac_out_r, clip_l, clip_r);
    end
    $display("saturation_pos: l=%0d clip_l=%b", dac_out_l, clip_l);
    for (int v = 0; v < 8; v++) set_voice(v, 16'h8000, 8'h7F, 8'h7F);
    wait_valid(c);
    n_vec++;
    if (c < 0 || dac_out_l !== -32768 || dac_out_r !== -32768 || clip_l !== 1'b1 || clip_r !== 1'b1) begin
      n_err++; $display("FAIL sat_neg: got l=%0d r=%0d cl=%b cr=%b want -32768 -32768 1 1",
                        dac_out_l, dac_out_r, clip_l, clip_r);
    end
    $display("saturation_neg: l=%0d clip_l=%b", dac_out_l, clip_l);
  endtask

  task automatic test_floor();
    int c;
    voice_samples = '0; voice_vol_l = '0; voice_vol_r = '0;
    set_voice(0, 16'hFFFF, 8'h01, 8'h00);
    set_voice(1, 16'h0100, 8'h00, 8'h80);
    voice_enable = 8'h03; master_vol_l = 8'h7F; master_vol_r = 8'h7F;
    wait_valid(c);
    n_vec++;
    if (c < 0 || dac_out_l !== -1 || dac_out_r !== -254 || clip_l !== 1'b0 || clip_r !== 1'b0) begin
      n_err++; $display("FAIL floor: got l=%0d r=%0d cl=%b cr=%b want -1 -254 0 0",
                        dac_out_l, dac_out_r, clip_l, clip_r);
    end
    $display("floor: l=%0d r=%0d", dac_out_l, dac_out_r);
  endtask

  task automatic test_min_volume();
    int c;
    voice_samples = '0; voice_vol_l = '0; voice_vol_r = '0;
    set_voice(0, 16'h8000, 8'h80, 8'h80);
    voice_enable = 8'h01; master_vol_l = 8'h80; master_vol_r = 8'h7F;
    wait_valid(c);
    n_vec++;
    if (c < 0 || dac_out_l !== -32768 || clip_l !== 1'b0) begin
      n_err++; $display("FAIL minvol_l: got l=%0d clip=%b want -32768 0", dac_out_l, clip_l);
    end
    n_vec++;
    if (dac_out_r !== 32512 || clip_r !== 1'b0) begin
      n_err++; $display("FAIL minvol_r: got r=%0d clip=%b want 32512 0", dac_out_r, clip_r);
    end
    $display("min_volume: l=%0d r=%0d", dac_out_l, dac_out_r);
  endtask

  task automatic test_enable_mute();
    int c;
    for (int v = 0; v < 8; v++) set_voice(v, 16'h1000, 8'h40, 8'h40);
    voice_enable = 8'h05; master_vol_l = 8'h7F; master_vol_r = 8'h7F;
    wait_valid(c);
    n_vec++;
    if (c < 0 || dac_out_l !== 4064 || dac_out_r !== 4064) begin
      n_err++; $display("FAIL enable: got l=%0d r=%0d want 4064 4064", dac_out_l, dac_out_r);
    end
    mute = 1'b1;
    wait_valid(c);
    n_vec++;
    if (c != 64 || dac_out_l !== 0 || dac_out_r !== 0) begin
      n_err++; $display("FAIL mute: got gap=%0d l=%0d r=%0d want 64 0 0", c, dac_out_l, dac_out_r);
    end
    mute = 1'b0;
    wait_valid(c);
    n_vec++;
    if (c < 0 || dac_out_l !== 4064 || dac_out_r !== 4064) begin
      n_err++; $display("FAIL unmute: got l=%0d r=%0d want 4064 4064", dac_out_l, dac_out_r);
    end
    $display("enable_mute: l=%0d after unmute", dac_out_l);
  endtask

  task automatic test_reset_mid_frame();
    int c;
    bit found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (step == 6'd30) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found) begin
      n_err++; $display("FAIL midreset_find_step: got step=%0d want 30", step);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_vec++;
    if (dac_out_l !== 0 || dac_out_r !== 0 || dac_valid !== 1'b0 || step !== 6'd0) begin
      n_err++; $display("FAIL midreset_state: got l=%0d r=%0d v=%b step=%0d want 0 0 0 0",
                        dac_out_l, dac_out_r, dac_valid, step);
    end
    wait_valid(c);
    n_vec++;
    if (c != 64 || dac_out_l !== 4064) begin
      n_err++; $display("FAIL midreset_recover: got gap=%0d l=%0d want 64 4064", c, dac_out_l);
    end
    $display("reset_mid_frame: recovered after %0d cycles", c);
  endtask

  task automatic test_param_sweep();
    int c;
    wait_valid2(c);
    s2 = '0; vl2 = '0; vr2 = '0;
    s2[15:0] = 16'd12345; vl2[11:0] = 12'd1500; vr2[11:0] = 12'h800;
    en2 = 4'h1; ml2 = 12'd2000; mr2 = 12'd2047;
    wait_valid2(c);
    n_vec++;
    if (c != 7) begin
      n_err++; $display("FAIL sweep_period: got %0d want 7", c);
    end
    n_vec++;
    if (dl2 !== 8829 || dr2 !== -12339 || cl2 !== 1'b0 || cr2 !== 1'b0) begin
      n_err++; $display("FAIL sweep_value: got l=%0d r=%0d cl=%b cr=%b want 8829 -12339 0 0",
                        dl2, dr2, cl2, cr2);
    end
    for (int i = 1; i <= 13; i++) begin
      @(negedge clock);
      n_vec++;
      if (step2 !== 6'(i % 7)) begin
        n_err++; $display("FAIL sweep_step: got %0d want %0d", step2, i % 7);
      end
    end
    wait_valid2(c);
    for (int v = 0; v < 4; v++) begin
      s2[v*16 +: 16] = 16'(-30000);
      vl2[v*12 +: 12] = 12'd2047;
      vr2[v*12 +: 12] = 12'd0;
    end
    en2 = 4'hF; ml2 = 12'd2047; mr2 = 12'd0;
    wait_valid2(c);
    n_vec++;
    if (c < 0 || dl2 !== -32768 || cl2 !== 1'b1 || dr2 !== 0 || cr2 !== 1'b0) begin
      n_err++; $display("FAIL sweep_sat: got l=%0d cl=%b r=%0d cr=%b want -32768 1 0 0",
                        dl2, cl2, dr2, cr2);
    end
    $display("param_sweep: l=%0d clip_l=%b", dl2, cl2);
  endtask

  initial begin
    test_reset();
    test_single_voice();
    test_saturation();
    test_floor();
    test_min_volume();
    test_enable_mute();
    test_reset_mid_frame();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
